// File: rtl/branch_pred_one_bit.sv
// branch_pred_one_bit
//   One-bit dynamic branch predictor. Holds a table of 2**INDEX_W single-bit
//   entries. Each entry stores the last resolved direction (1 = taken) of the
//   branches that map to it. Every clock with reset released counts as one
//   resolution: the entry selected by branch_index is compared against the
//   actual outcome and then overwritten with that outcome.
//
// Ports
//   clk              in   rising-edge clock for all state
//   rst_n            in   synchronous, active-low reset
//   branch_index     in   table entry of the branch resolving this cycle
//   branch_action    in   outcome vector; only bit[branch_index] is used
//   branch_update    out  registered: last resolved branch was mispredicted
//   branch_history   out  registered table contents, bit i = entry i
//   branch_predict   out  combinational: branch_history[branch_index]
//   mispredict_count out  registered saturating misprediction counter
module branch_pred_one_bit #(
    parameter int unsigned INDEX_W    = 1,
    parameter logic        RESET_PRED = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INDEX_W-1:0]      branch_index,
    input  logic [2**INDEX_W-1:0]   branch_action,
    output logic                    branch_update,
    output logic [2**INDEX_W-1:0]   branch_history,
    output logic                    branch_predict,
    output logic [CNT_W-1:0]        mispredict_count
);

    localparam int unsigned ENTRIES = 2**INDEX_W;

    logic [ENTRIES-1:0] table_q;
    logic [ENTRIES-1:0] table_d;
    logic               outcome;
    logic               mispredict;
    logic               update_q;
    logic [CNT_W-1:0]   count_q;

    assign outcome        = branch_action[branch_index];
    assign branch_predict = table_q[branch_index];
    assign mispredict     = branch_predict ^ outcome;

    // Only the indexed entry is rewritten; all other entries hold.
    always_comb begin
        table_d               = table_q;
        table_d[branch_index] = outcome;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            table_q  <= {ENTRIES{RESET_PRED}};
            update_q <= 1'b0;
            count_q  <= '0;
        end else begin
            table_q  <= table_d;
            update_q <= mispredict;
            if (mispredict && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign branch_update    = update_q;
    assign branch_history   = table_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_pred_one_bit.sv
// tb_branch_pred_one_bit
//   Directed bench for branch_pred_one_bit. Three instances share the same
//   stimulus: default parameters, a 2-bit saturating counter, and RESET_PRED=1.
module tb_branch_pred_one_bit;

    logic        clk_tb = 1'b0;
    logic        rst_n;
    logic [0:0]  branch_index;
    logic [1:0]  branch_action;

    logic        upd_a, pred_a;
    logic [1:0]  hist_a;
    logic [15:0] cnt_a;

    logic        upd_s, pred_s;
    logic [1:0]  hist_s;
    logic [1:0]  cnt_s;

    logic        upd_r, pred_r;
    logic [1:0]  hist_r;
    logic [15:0] cnt_r;

    int total = 0;
    int bad   = 0;

    always #5 clk_tb = ~clk_tb;

    branch_pred_one_bit dut (
        .clk(clk_tb), .rst_n(rst_n), .branch_index(branch_index),
        .branch_action(branch_action), .branch_update(upd_a),
        .branch_history(hist_a), .branch_predict(pred_a),
        .mispredict_count(cnt_a)
    );

    branch_pred_one_bit #(.CNT_W(2)) dut_sat (
        .clk(clk_tb), .rst_n(rst_n), .branch_index(branch_index),
        .branch_action(branch_action), .branch_update(upd_s),
        .branch_history(hist_s), .branch_predict(pred_s),
        .mispredict_count(cnt_s)
    );

    branch_pred_one_bit #(.RESET_PRED(1'b1)) dut_rp1 (
        .clk(clk_tb), .rst_n(rst_n), .branch_index(branch_index),
        .branch_action(branch_action), .branch_update(upd_r),
        .branch_history(hist_r), .branch_predict(pred_r),
        .mispredict_count(cnt_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk_tb);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        branch_index  = 1'b0;
        branch_action = 2'b00;
        #2;
        step();
        check("rst_hist",     32'(hist_a), 32'h0);
        check("rst_upd",      32'(upd_a),  32'h0);
        check("rst_cnt",      32'(cnt_a),  32'h0);
        check("rst_pred",     32'(pred_a), 32'h0);
        check("rst_sat_cnt",  32'(cnt_s),  32'h0);
        check("rst_rp1_hist", 32'(hist_r), 32'h3);
        check("rst_rp1_pred", 32'(pred_r), 32'h1);

        // Entry 0 trained taken from not-taken: mispredict.
        rst_n         = 1'b1;
        branch_index  = 1'b0;
        branch_action = 2'b01;
        step();
        check("t2a_hist",     32'(hist_a), 32'h1);
        check("t2a_upd",      32'(upd_a),  32'h1);
        check("t2a_cnt",      32'(cnt_a),  32'h1);
        check("t2a_rp1_upd",  32'(upd_r),  32'h0);
        check("t2a_rp1_hist", 32'(hist_r), 32'h3);
        step();
        check("t2b_hist", 32'(hist_a), 32'h1);
        check("t2b_upd",  32'(upd_a),  32'h0);
        check("t2b_cnt",  32'(cnt_a),  32'h1);

        // Entry 1 trained taken; entry 0 must hold.
        branch_index  = 1'b1;
        branch_action = 2'b10;
        step();
        check("t3_hist",   32'(hist_a),    32'h3);
        check("t3_upd",    32'(upd_a),     32'h1);
        check("t3_cnt",    32'(cnt_a),     32'h2);
        check("t3_entry0", 32'(hist_a[0]), 32'h1);

        // bit1=0 is the outcome; bit0 set must be ignored.
        branch_action = 2'b01;
        step();
        check("t4_hist",      32'(hist_a), 32'h1);
        check("t4_upd",       32'(upd_a),  32'h1);
        check("t4_cnt",       32'(cnt_a),  32'h3);
        check("t4_pred_idx1", 32'(pred_a), 32'h0);
        check("t4_sat_cnt",   32'(cnt_s),  32'h3);
        branch_index = 1'b0;
        #1;
        check("t4_pred_idx0", 32'(pred_a), 32'h1);

        // Alternating N/T on entry 0 (currently taken): every edge mispredicts.
        for (int k = 0; k < 10; k++) begin
            branch_action = {1'b0, 1'(k % 2)};
            step();
            check($sformatf("t5_upd_%0d", k), 32'(upd_a), 32'h1);
        end
        check("t5_cnt",     32'(cnt_a),  32'd13);
        check("t5_hist",    32'(hist_a), 32'h1);
        check("t5_sat_cnt", 32'(cnt_s),  32'h3);

        // Reset on an edge that would otherwise mispredict (entry 0 is taken).
        branch_action = 2'b00;
        rst_n         = 1'b0;
        step();
        check("t6_hist",      32'(hist_a), 32'h0);
        check("t6_upd",       32'(upd_a),  32'h0);
        check("t6_cnt",       32'(cnt_a),  32'h0);
        check("t6_sat_cnt",   32'(cnt_s),  32'h0);
        check("t6_rp1_hist",  32'(hist_r), 32'h3);
        check("t6_rp1_cnt",   32'(cnt_r),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
